load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width of request and memory ports.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning a request is offered.
REQ-005 SHALL have port req_ready, output, 1, meaning the unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width code: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, meaning misaligned address or illegal funct3.
REQ-013 SHALL have port mem_address, output, ADDR_WIDTH, word-aligned byte address (bits [1:0] always 00).
REQ-014 SHALL have port mem_write_enable, output, 1, word write strobe, sampled by the memory on the clk rising edge.
REQ-015 SHALL have port mem_write_data, output, 32, full word to write.
REQ-016 SHALL have port mem_read_data, input, 32, combinational read of the word at mem_address.

Function
REQ-017 SHALL implement states IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, latching we, funct3, addr and wdata.
REQ-019 SHALL flag an error on acceptance if funct3 is illegal for the direction, if LH/LHU/SH has addr[0]=1, or if LW/SW has addr[1:0]!=00.
REQ-020 SHALL transition on acceptance IDLE->RESP for an error, ->LOAD for a legal load, ->WRITE for SW, and ->RMW_READ for SB/SH.
REQ-021 SHALL drive mem_address = {latched addr[ADDR_WIDTH-1:2], 2'b00} in LOAD, RMW_READ and WRITE.
REQ-022 In LOAD, SHALL register the selected byte/halfword of mem_read_data (lane = addr[1:0], little-endian) into rsp_rdata: sign-extended for LB/LH, zero-extended for LBU/LHU, whole word for LW; then go to RESP.
REQ-023 In RMW_READ, SHALL register the old word with the addressed byte (SB) or halfword (SH) replaced by req_wdata[7:0] or [15:0], leaving other lanes unchanged, as mem_write_data; then go to WRITE.
REQ-024 For SW, SHALL set mem_write_data to the latched wdata.
REQ-025 SHALL assert mem_write_enable for exactly one cycle, in WRITE only, and then go to RESP.
REQ-026 In RESP, SHALL assert rsp_valid for exactly one cycle, with rsp_err=1 and rsp_rdata=0 on error, then return to IDLE; no memory write occurs for an errored request.
REQ-027 Latency, in cycles from the accept edge to the rsp_valid cycle: error 1, LW/LB/LH/LBU/LHU 2, SW 2, SB/SH 3.
REQ-028 rsp_valid SHALL have no backpressure; the next request is accepted no earlier than the cycle after RESP.
REQ-029 SHALL hold mem_write_enable=0 and rsp_valid=0 outside WRITE and RESP respectively; req_valid is ignored outside IDLE.

Reset
REQ-030 While rst=1, SHALL force mem_write_enable=0 combinationally, so that no write is committed even if rst arrives during WRITE.
REQ-031 On a rising edge with rst=1, SHALL enter IDLE and clear rsp_valid, rsp_err, rsp_rdata, mem_address and mem_write_data to 0, aborting any in-flight request with no response.
REQ-032 SHALL drive req_ready=0 in the cycle rst is high and req_ready=1 in the first cycle after reset is released.

Verification
REQ-033 Reset with a zero-initialised 64-word memory, then LW at 0x0/0x4/0xFC -> rsp_rdata=0, rsp_err=0, two-cycle latency each.
REQ-034 SW 0xDEADBEEF at 0x8, then LB 0xB -> rsp_rdata 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0xA -> 0xFFFFDEAD; LHU 0x8 -> 0x0000BEEF.
REQ-035 Memory word at 0xC = 0x12345678; SB 0xA5 at 0xD, then SH 0xCAFE at 0xE, then LW 0xC -> 0xCAFEA578; each store has one mem_write_enable pulse.
REQ-036 LW 0x6, SH 0x3, LH 0x1, load funct3=011, store funct3=100 -> rsp_err=1, rsp_rdata=0, one-cycle latency, mem_write_enable never asserted, memory unchanged.
REQ-037 rst asserted in the WRITE cycle of SB 0xFF at 0x10 -> no write (word at 0x10 unchanged), no rsp_valid, req_ready=1 the cycle after rst deasserts.
REQ-038 req_valid held high continuously across 64 SW requests (data i*100 at i<<2), then 64 LW -> all readbacks match; req_ready low in every non-IDLE cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte/half/word load-store unit over a single-ported word memory
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [31:0]             rsp_rdata_q;
    logic [31:0]             mem_wdata_q;

    logic                    req_err_d;
    logic [31:0]             load_result_d;
    logic [31:0]             merged_word_d;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;

    // Illegal width code for the direction, or an address not aligned to the access size.
    always_comb begin
        logic legal;
        logic misaligned;
        legal = 1'b0;
        misaligned = 1'b0;
        if (req_we) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err_d = !legal || misaligned;
    end

    assign rd_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_result_d = mem_read_data;
        case (funct3_q)
            3'b000:  load_result_d = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_result_d = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_result_d = {24'h0, rd_byte};
            3'b101:  load_result_d = {16'h0, rd_half};
            default: load_result_d = mem_read_data;
        endcase
    end

    // Sub-word store: splice the new lane into the word just read back.
    always_comb begin
        merged_word_d = mem_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            merged_word_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_word_d[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata[15:0];
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= req_err_d;
                        if (req_err_d) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (!req_we) begin
                            state_q <= S_LOAD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            mem_wdata_q <= req_wdata;
                            state_q     <= S_WRITE;
                        end else begin
                            state_q <= S_RMW_READ;
                        end
                    end
                end
                S_LOAD: begin
                    rsp_rdata_q <= load_result_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RMW_READ: begin
                    mem_wdata_q <= merged_word_d;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Reset gates the strobe directly so a write in flight is never committed.
    assign req_ready        = (state_q == S_IDLE) && !rst;
    assign mem_write_enable = (state_q == S_WRITE) && !rst;
    assign mem_address      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write_data   = mem_wdata_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_rdata        = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem_w [64];
    logic        mem_init;
    logic [7:0]  refmem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    // 64-word memory the unit talks to: combinational read, write on the rising edge.
    assign mem_read_data = mem_w[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 64; w++) mem_w[w] <= 32'h0;
        end else if (mem_write_enable) begin
            mem_w[mem_address[7:2]] <= mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {refmem[4*w+3], refmem[4*w+2], refmem[4*w+1], refmem[4*w]};
    endfunction

    task automatic chk_mem_image(input string tag);
        int bad = 0;
        for (int w = 0; w < 64; w++) if (mem_w[w] !== ref_word(w)) bad++;
        chk(tag, bad, 0);
    endtask

    // One request end to end; the expected outcome comes from the byte-level model.
    task automatic do_req(input bit we, input bit [2:0] f3, input bit [7:0] a,
                          input bit [31:0] wd, input bit hold, output logic [31:0] rd);
        int size, lat_exp, wr_exp, n, lat, wr, busy_bad;
        bit legal, err_exp, got;
        logic [31:0] rd_exp;
        logic er;
        longint val;

        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err_exp = !legal || ((a % size) != 0);
        rd_exp = 32'h0;
        if (err_exp) begin
            lat_exp = 1; wr_exp = 0;
        end else if (!we) begin
            lat_exp = 2; wr_exp = 0;
            val = 0;
            for (int k = 0; k < size; k++) val += longint'(refmem[a + k]) * (longint'(1) << (8 * k));
            if (f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= (longint'(1) << (8 * size));
            rd_exp = val[31:0];
        end else begin
            lat_exp = (size == 4) ? 2 : 3; wr_exp = 1;
            for (int k = 0; k < size; k++) refmem[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
        end

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = {24'h0, a}; req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", n >= 20, 0);
        @(posedge clk);
        lat = 0; wr = 0; busy_bad = 0; got = 0; rd = 'x; er = 1'bx;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (!hold) req_valid = 1'b0;
            if (mem_write_enable === 1'b1) wr++;
            if (req_ready !== 1'b0) busy_bad++;
            if (rsp_valid === 1'b1) begin got = 1; rd = rsp_rdata; er = rsp_err; end
        end
        chk("rsp_seen", got, 1);
        chk("latency", lat, lat_exp);
        chk("rsp_err", er, err_exp);
        chk("rsp_rdata", rd, rd_exp);
        chk("write_pulses", wr, wr_exp);
        chk("ready_low_busy", busy_bad, 0);
        @(negedge clk);
        chk("rsp_single_cycle", rsp_valid, 0);
        chk("ready_after_resp", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          rw;
        bit [2:0]    rf3;
        bit [7:0]    ra;

        for (int i = 0; i < 256; i++) refmem[i] = 8'h0;
        rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready_low", req_ready, 0);
        chk("reset_we_low", mem_write_enable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", req_ready, 1);
        chk("post_reset_rsp_valid", rsp_valid, 0);
        chk("post_reset_rsp_err", rsp_err, 0);
        chk("post_reset_rsp_rdata", rsp_rdata, 0);
        chk("post_reset_mem_address", mem_address, 0);
        chk("post_reset_mem_wdata", mem_write_data, 0);

        do_req(0, 3'b010, 8'h00, 0, 0, rd); chk("lw_0", rd, 32'h0);
        do_req(0, 3'b010, 8'h04, 0, 0, rd); chk("lw_4", rd, 32'h0);
        do_req(0, 3'b010, 8'hFC, 0, 0, rd); chk("lw_fc", rd, 32'h0);

        do_req(1, 3'b010, 8'h08, 32'hDEADBEEF, 0, rd);
        do_req(0, 3'b000, 8'h0B, 0, 0, rd); chk("lb_b", rd, 32'hFFFFFFDE);
        do_req(0, 3'b100, 8'h0B, 0, 0, rd); chk("lbu_b", rd, 32'h000000DE);
        do_req(0, 3'b001, 8'h0A, 0, 0, rd); chk("lh_a", rd, 32'hFFFFDEAD);
        do_req(0, 3'b101, 8'h08, 0, 0, rd); chk("lhu_8", rd, 32'h0000BEEF);

        do_req(1, 3'b010, 8'h0C, 32'h12345678, 0, rd);
        do_req(1, 3'b000, 8'h0D, 32'h000000A5, 0, rd);
        do_req(1, 3'b001, 8'h0E, 32'h0000CAFE, 0, rd);
        do_req(0, 3'b010, 8'h0C, 0, 0, rd); chk("rmw_word_c", rd, 32'hCAFEA578);

        do_req(0, 3'b010, 8'h06, 0, 0, rd);
        do_req(1, 3'b001, 8'h03, 32'h1234, 0, rd);
        do_req(0, 3'b001, 8'h01, 0, 0, rd);
        do_req(0, 3'b011, 8'h00, 0, 0, rd);
        do_req(1, 3'b100, 8'h00, 32'hFFFFFFFF, 0, rd);
        chk_mem_image("mem_after_errors");

        // Reset lands in the WRITE cycle of an SB: the write must not happen.
        do_req(1, 3'b010, 8'h10, 32'h11223344, 0, rd);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_rmw_no_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("abort_in_write", mem_write_enable, 1);
        rst = 1'b1;
        #1;
        chk("abort_we_gated", mem_write_enable, 0);
        @(negedge clk);
        chk("abort_rst_no_rsp", rsp_valid, 0);
        chk("abort_rst_ready_low", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", req_ready, 1);
        chk("abort_no_rsp_after", rsp_valid, 0);
        chk("abort_word_10", mem_w[4], 32'h11223344);

        for (int i = 0; i < 64; i++) do_req(1, 3'b010, 8'(i << 2), 32'(i * 100), 1, rd);
        for (int i = 0; i < 64; i++) begin
            do_req(0, 3'b010, 8'(i << 2), 0, 1, rd);
            chk("stream_readback", rd, 32'(i * 100));
        end
        req_valid = 1'b0;

        for (int i = 0; i < 150; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (rf3[1:0] == 2'd1) ra[0] = 1'b0;
                else if (rf3[1:0] != 2'd0) ra[1:0] = 2'b00;
            end
            do_req(rw, rf3, ra, $urandom, $urandom_range(0, 1) == 1, rd);
        end
        req_valid = 1'b0;
        chk_mem_image("mem_after_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
